// File: rtl/dds_pkg.sv
// Shared DDS definitions: sample/note widths and the note-increment table
// used by the sequencer, the generator and the note decoder.
package dds_pkg;

    localparam int DDS_W             = 32;
    localparam int NOTE_W            = 8;
    localparam int NUM_NOTES_DEFAULT = 16;
    localparam int NOTE_IDX_W        = $clog2(NUM_NOTES_DEFAULT);

    localparam logic [DDS_W-1:0] NOTE_INC [NUM_NOTES_DEFAULT] = '{
        32'h0100_0000, 32'h010F_3A7C, 32'h011F_8A6D, 32'h0130_FCDA,
        32'h0143_9B6E, 32'h0157_7A4B, 32'h016C_A3E1, 32'h0183_22C0,
        32'h019B_0F4F, 32'h01B4_6D4A, 32'h01CF_5A9E, 32'h01EB_D8F0,
        32'h0200_0000, 32'h021E_74F8, 32'h023F_14DA, 32'h0261_F9B6
    };

    // Indices past the table read as 0, which a search never matches
    // because a zero increment goes straight to the silent state.
    function automatic logic [DDS_W-1:0] note_inc(input logic [NOTE_W-1:0] i);
        if (i < NOTE_W'(NUM_NOTES_DEFAULT))
            return NOTE_INC[i[NOTE_IDX_W-1:0]];
        else
            return '0;
    endfunction

endpackage

// File: rtl/dds_delta_tracker.sv
// Measures the per-sample phase increment of a DDS accumulator stream and
// reports when it has stayed identical for LOCK_COUNT samples.
module dds_delta_tracker
    import dds_pkg::*;
#(
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DDS_W-1:0] dds_in,
    input  logic             dds_valid,
    output logic [DDS_W-1:0] last_delta,
    output logic             locked,
    output logic             delta_change
);

    localparam int CNT_W = $clog2(LOCK_COUNT + 1);

    logic [DDS_W-1:0] prev_p0;
    logic             have_prev_p0;
    logic [CNT_W-1:0] cnt_p1;
    logic [DDS_W-1:0] delta;
    logic [CNT_W-1:0] cnt_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == CNT_W'(LOCK_COUNT))
            return c;
        else
            return c + CNT_W'(1);
    endfunction

    // Modular subtraction makes an accumulator wrap yield the true increment.
    always_comb begin
        delta        = dds_in - prev_p0;
        cnt_nxt      = (delta == last_delta) ? sat_inc(cnt_p1) : CNT_W'(1);
        delta_change = dds_valid && have_prev_p0 && (delta != last_delta);
    end

    // p0: previous sample capture
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_p0      <= '0;
            have_prev_p0 <= 1'b0;
        end else if (dds_valid) begin
            prev_p0      <= dds_in;
            have_prev_p0 <= 1'b1;
        end
    end

    // p1: increment history and stability count
    always_ff @(posedge clk) begin
        if (reset) begin
            last_delta <= '0;
            cnt_p1     <= '0;
            locked     <= 1'b0;
        end else if (dds_valid && have_prev_p0) begin
            last_delta <= delta;
            cnt_p1     <= cnt_nxt;
            locked     <= (cnt_nxt == CNT_W'(LOCK_COUNT));
        end
    end

endmodule

// File: rtl/dds_note_decoder.sv
// Recovers the note index that produced a DDS phase-accumulator stream by
// locking onto a stable increment and searching the shared increment table.
module dds_note_decoder
    import dds_pkg::*;
#(
    parameter int          NUM_NOTES  = NUM_NOTES_DEFAULT,
    parameter int          LOCK_COUNT = 4,
    parameter int unsigned TOL        = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DDS_W-1:0]  dds_in,
    input  logic              dds_valid,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_valid,
    output logic              locked,
    output logic              no_match,
    output logic              silent,
    output logic [DDS_W-1:0]  delta_out
);

    typedef enum logic [1:0] {IDLE, SEARCH, HOLD} state_t;

    state_t            state, state_nxt;
    logic [NOTE_W-1:0] idx, idx_nxt;
    logic [NOTE_W-1:0] note_out_nxt;
    logic              note_valid_nxt, no_match_nxt, silent_nxt;
    logic [DDS_W-1:0]  last_delta;
    logic              delta_change;

    dds_delta_tracker #(
        .LOCK_COUNT(LOCK_COUNT)
    ) u_tracker (
        .clk         (clk),
        .reset       (reset),
        .dds_in      (dds_in),
        .dds_valid   (dds_valid),
        .last_delta  (last_delta),
        .locked      (locked),
        .delta_change(delta_change)
    );

    assign delta_out = last_delta;

    // 33-bit signed difference so the magnitude never overflows.
    function automatic logic within_tol(input logic [DDS_W-1:0] a,
                                        input logic [DDS_W-1:0] b);
        logic signed [DDS_W:0] d;
        logic        [DDS_W:0] mag;
        d   = $signed({1'b0, a}) - $signed({1'b0, b});
        mag = (d < 0) ? (DDS_W+1)'(-d) : (DDS_W+1)'(d);
        return mag <= (DDS_W+1)'(TOL);
    endfunction

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        note_out_nxt   = note_out;
        note_valid_nxt = note_valid;
        no_match_nxt   = no_match;
        silent_nxt     = silent;
        if (dds_valid) begin
            unique case (state)
                IDLE: begin
                    if (locked && !delta_change) begin
                        if (last_delta != '0) begin
                            state_nxt = SEARCH;
                            idx_nxt   = '0;
                        end else begin
                            state_nxt  = HOLD;
                            silent_nxt = 1'b1;
                        end
                    end
                end
                SEARCH: begin
                    if (delta_change) begin
                        state_nxt = IDLE;
                    end else if (within_tol(last_delta, note_inc(idx))) begin
                        note_out_nxt   = idx;
                        note_valid_nxt = 1'b1;
                        no_match_nxt   = 1'b0;
                        state_nxt      = HOLD;
                    end else if (idx == NOTE_W'(NUM_NOTES - 1)) begin
                        no_match_nxt = 1'b1;
                        state_nxt    = HOLD;
                    end else begin
                        idx_nxt = idx + NOTE_W'(1);
                    end
                end
                HOLD: begin
                    if (delta_change) begin
                        state_nxt      = IDLE;
                        note_valid_nxt = 1'b0;
                        no_match_nxt   = 1'b0;
                        silent_nxt     = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            note_out   <= '0;
            note_valid <= 1'b0;
            no_match   <= 1'b0;
            silent     <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            note_out   <= note_out_nxt;
            note_valid <= note_valid_nxt;
            no_match   <= no_match_nxt;
            silent     <= silent_nxt;
        end
    end

endmodule
